logic_unit: RTL and testbench
=============================

# logic_unit

Parametrised, handshaked successor to the team's two-input gate-level logic model. Applies one of eight bitwise logic operations to two WIDTH-bit operands and queues the results in a 2-entry output buffer behind a valid/ready interface. Sits between an operand producer and a consumer that may stall. Also keeps a running count of accepted operations.

## Interface
- WIDTH, 8: operand and result width in bits (≥1).
- CNT_W, 16: width of the accepted-operation counter (≥1).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  operand set offered.
- in_ready  out  1  unit can accept; high when fewer than 2 entries are buffered.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  operation select.
- out_valid  out  1  head entry valid; equals (count != 0).
- out_ready  in  1  consumer takes the head entry.
- y  out  WIDTH  head entry result.
- zero  out  1  head entry flag: result was all zeros.
- op_count  out  CNT_W  number of accepted operations, modulo 2^CNT_W.
- parity  out  1  head entry XOR-reduction of result; present only with LOGIC_UNIT_REDUCE_EN.

## Operation
- Opcodes: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 NOT b (a ignored), 5 XOR, 6 XNOR, 7 PASS a (b ignored).
- The result is computed combinationally from a, b and op. It is written with its zero flag, and parity if enabled, into the buffer on accept.
- Accept (push) = in_valid & in_ready.
- Pop = out_valid & out_ready.
- Buffer: 2 entries, write pointer, read pointer and a 2-bit count (0..2). Pointers wrap 1→0.
- Push only: count +1. Pop only: count −1. Push and pop together: count unchanged, head advances, new entry written at the tail.
- in_ready = (count < 2). It does not depend on out_ready in the same cycle, so a full buffer with a simultaneous pop still refuses the push that cycle.
- Pop when empty is impossible, because out_valid=0.
- op_count increments by 1 on each accept and wraps from 2^CNT_W−1 to 0.
- y, zero and parity show the head entry. Stored entry data is held stable while out_valid=1 and out_ready=0.
- Inputs a, b and op are ignored when the push condition is false.

## Timing
- Reset (rst=1 at an edge): count=0, pointers=0, all entries cleared to 0, op_count=0.
- Output values after reset: out_valid=0, in_ready=1, y=0, zero=0, parity=0.
- Reset has priority over push and pop in the same cycle. Entries in flight are discarded.
- Latency: an operand accepted at edge N appears on y with out_valid=1 after edge N, provided the buffer was empty before N.
- Throughput: 1 result per cycle while out_ready=1.
- With out_ready held low, exactly 2 accepts complete before in_ready falls, one cycle after the second accept.
- in_ready rises in the cycle after the first pop from a full buffer.
- No combinational path from in_valid, a, b or op to any output. No combinational path from out_ready to in_ready.

## Configuration
- LOGIC_UNIT_REDUCE_EN defined:
  - Each buffer entry stores one extra bit, ^result.
  - The parity port exists and shows the head entry's bit.
  - Parity resets to 0.
- LOGIC_UNIT_REDUCE_EN undefined:
  - No parity storage and no parity port.
  - All other behaviour is identical.

## Test plan
- Truth table: WIDTH=8, out_ready=1. a=8'hF0, b=8'hCC, op=0..7 on consecutive cycles. Required y sequence: 8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h33, 8'h3C, 8'hC3, 8'hF0; each one cycle after its accept. zero=0 throughout. op_count ends at 8.
- Zero flag / parity: a=8'h0F, b=8'hF0, op=0 gives y=8'h00, zero=1, parity=0. a=8'h07, b=8'h00, op=7 gives y=8'h07, zero=0, parity=1 (parity checks only with the macro defined).
- Backpressure: out_ready=0, in_valid=1 for 4 cycles with a=1,2,3,4 and op=7. Only 1 and 2 are accepted; in_ready=0 from the cycle after the second accept. Raising out_ready drains 1 then 2; then 3 (held input) is accepted.
- Simultaneous push/pop at count=1: count stays 1, out_valid stays 1, y advances to the new result on the next cycle, op_count increments.
- Counter wrap: CNT_W=4, 17 accepts. op_count reads 15 after the 15th accept, 0 after the 16th, 1 after the 17th.
- Reset mid-operation: buffer full with two results, op_count=5. Assert rst for 1 cycle with in_valid=1. Next cycle: out_valid=0, in_ready=1, y=0, zero=0, op_count=0. No entry survives.

Source files
------------

// File: rtl/logic_unit.sv
// logic_unit: applies one of eight bitwise operations to two WIDTH-bit
// operands and queues each result, with its zero flag, in a 2-entry buffer
// behind a valid/ready interface. Also counts accepted operations.
//
// Optional feature macro: LOGIC_UNIT_REDUCE_EN. When it is defined, each
// entry also stores the XOR-reduction of its result, and that bit is
// shown on the parity port.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand set offered
//   in_ready   out  buffer holds fewer than 2 entries
//   a, b       in   WIDTH-bit operands
//   op         in   3-bit operation select
//   out_valid  out  head entry valid
//   out_ready  in   consumer takes the head entry
//   y          out  head entry result
//   zero       out  head entry result was all zeros
//   op_count   out  accepted operations, modulo 2^CNT_W
//   parity     out  head entry XOR-reduction (LOGIC_UNIT_REDUCE_EN only)
module logic_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_REDUCE_EN
  ,
  output logic             parity
`endif
);

  // Bitwise operation selected by the opcode.
  function automatic logic [WIDTH-1:0] calc_result(
    input logic [WIDTH-1:0] fa,
    input logic [WIDTH-1:0] fb,
    input logic [2:0]       fop
  );
    logic [WIDTH-1:0] r;
    case (fop)
      3'd0:    r = fa & fb;
      3'd1:    r = fa | fb;
      3'd2:    r = ~(fa & fb);
      3'd3:    r = ~(fa | fb);
      3'd4:    r = ~fb;
      3'd5:    r = fa ^ fb;
      3'd6:    r = ~(fa ^ fb);
      3'd7:    r = fa;
      default: r = {WIDTH{1'b0}};
    endcase
    return r;
  endfunction

  // XOR-reduction of a result word.
  function automatic logic reduce_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic [WIDTH-1:0] y_mem_q [2];
  logic             z_mem_q [2];
`ifdef LOGIC_UNIT_REDUCE_EN
  logic             p_mem_q [2];
`endif
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic [WIDTH-1:0] result_s;
  logic             push_s;
  logic             pop_s;

  // in_ready depends only on stored occupancy, never on out_ready, so a
  // full buffer refuses a push even in a cycle where it is being popped.
  assign in_ready  = (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign result_s  = calc_result(a, b, op);

  assign y        = y_mem_q[rd_ptr_q];
  assign zero     = z_mem_q[rd_ptr_q];
  assign op_count = op_count_q;
`ifdef LOGIC_UNIT_REDUCE_EN
  assign parity   = p_mem_q[rd_ptr_q];
`endif

  // Next-state for occupancy, pointers and the accept counter.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    op_count_d = op_count_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push_s) begin
      wr_ptr_d   = wr_ptr_q + 1'b1;
      op_count_d = op_count_q + CNT_W'(1);
    end else begin
      wr_ptr_d   = wr_ptr_q;
      op_count_d = op_count_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State registers and buffer storage; reset clears every entry so the
  // head outputs read zero while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      op_count_q <= {CNT_W{1'b0}};
      for (int i = 0; i < 2; i++) begin
        y_mem_q[i] <= {WIDTH{1'b0}};
        z_mem_q[i] <= 1'b0;
`ifdef LOGIC_UNIT_REDUCE_EN
        p_mem_q[i] <= 1'b0;
`endif
      end
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      op_count_q <= op_count_d;
      if (push_s) begin
        y_mem_q[wr_ptr_q] <= result_s;
        z_mem_q[wr_ptr_q] <= (result_s == {WIDTH{1'b0}});
`ifdef LOGIC_UNIT_REDUCE_EN
        p_mem_q[wr_ptr_q] <= reduce_parity(result_s);
`endif
      end
    end
  end

endmodule

// File: tb/tb_logic_unit.sv
module tb_logic_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic [3:0] op_count;
`ifdef LOGIC_UNIT_REDUCE_EN
  logic       parity;
`endif

  int n_assert;
  int n_fail;
  int mopcnt;
  // Scoreboard entry: {expected y, expected zero, expected parity}
  logic [9:0] sb_q[$];

  logic [7:0] tt [8];

  logic_unit #(.WIDTH(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .zero      (zero),
    .op_count  (op_count)
`ifdef LOGIC_UNIT_REDUCE_EN
    ,
    .parity    (parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs against the scoreboard/model,
  // update the model with what the coming edge will do, advance a cycle.
  task automatic step(input logic iv, input logic [7:0] av, input logic [7:0] bv,
                      input logic [2:0] opv, input logic ordy, input logic [7:0] ey);
    logic       push;
    logic       pop;
    logic [9:0] hd;
    in_valid  = iv;
    a         = av;
    b         = bv;
    op        = opv;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
    chk("op_count", 32'(op_count), 32'(mopcnt % 16));
    if (sb_q.size() != 0) begin
      hd = sb_q[0];
      chk("y", 32'(y), 32'(hd[9:2]));
      chk("zero", 32'(zero), 32'(hd[1]));
`ifdef LOGIC_UNIT_REDUCE_EN
      chk("parity", 32'(parity), 32'(hd[0]));
`endif
    end
    push = iv && (sb_q.size() < 2);
    pop  = (sb_q.size() != 0) && ordy;
    if (pop) void'(sb_q.pop_front());
    if (push) begin
      sb_q.push_back({ey, (ey == 8'h00), ^ey});
      mopcnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    #1;
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_y"}, 32'(y), 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd0);
    chk({tag, "_op_count"}, 32'(op_count), 32'd0);
`ifdef LOGIC_UNIT_REDUCE_EN
    chk({tag, "_parity"}, 32'(parity), 32'd0);
`endif
  endtask

  // Reset for one edge with an operand offered; it must be discarded.
  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hFF;
    b         = 8'hFF;
    op        = 3'd0;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    sb_q.delete();
    mopcnt = 0;
    reset_checks("rst");
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    mopcnt    = 0;
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    op        = 3'd0;
    out_ready = 1'b0;
    tt = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h33, 8'h3C, 8'hC3, 8'hF0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_checks("init");

    // Truth table, one op per cycle with the consumer always ready
    for (int i = 0; i < 8; i++) step(1'b1, 8'hF0, 8'hCC, 3'(i), 1'b1, tt[i]);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
    chk("tt_op_count", 32'(op_count), 32'd8);

    // Zero flag and parity
    step(1'b1, 8'h0F, 8'hF0, 3'd0, 1'b1, 8'h00);
    step(1'b1, 8'h07, 8'h00, 3'd7, 1'b1, 8'h07);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);

    // Backpressure: 1 and 2 accepted, 3 held until space frees
    step(1'b1, 8'h01, 8'h00, 3'd7, 1'b0, 8'h01);
    step(1'b1, 8'h02, 8'h00, 3'd7, 1'b0, 8'h02);
    step(1'b1, 8'h03, 8'h00, 3'd7, 1'b0, 8'h03);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    step(1'b1, 8'h03, 8'h00, 3'd7, 1'b0, 8'h03);
    step(1'b1, 8'h03, 8'h00, 3'd7, 1'b1, 8'h03);
    chk("bp_in_ready_rise", 32'(in_ready), 32'd1);
    step(1'b1, 8'h03, 8'h00, 3'd7, 1'b1, 8'h03);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 8'(i), 8'h00, 3'd7, 1'b1, 8'(i));
      if (i >= 15) chk("wrap_op_count", 32'(op_count), 32'(i % 16));
    end
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);

    // Reset mid-operation with a full buffer and op_count=5
    do_reset();
    step(1'b1, 8'h11, 8'h22, 3'd5, 1'b1, 8'h33);
    step(1'b1, 8'hAA, 8'h0F, 3'd1, 1'b1, 8'hAF);
    step(1'b1, 8'h55, 8'hFF, 3'd6, 1'b1, 8'h55);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
    step(1'b1, 8'h5A, 8'h00, 3'd4, 1'b0, 8'hFF);
    step(1'b1, 8'h81, 8'h00, 3'd7, 1'b0, 8'h81);
    chk("mid_op_count", 32'(op_count), 32'd5);
    chk("mid_full", 32'(in_ready), 32'd0);
    do_reset();
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
